// File: rtl/packet_injector.sv
// packet_injector: injection-side network interface feeding a Router LOCAL port.
// Takes a packet descriptor (destination, payload length) plus a stream of
// payload words and emits HEAD, BODY..., TAIL flits using req / on-off flow
// control. Payload words are prefetched into a small FIFO and may arrive
// before their descriptor.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   i_desc_valid / o_desc_ready    descriptor handshake
//   i_desc_dst_x, i_desc_dst_y     destination column / row
//   i_desc_len                     payload flits in the packet (1..MAX_LEN)
//   i_pl_valid / o_pl_ready        payload word handshake (ready = FIFO not full)
//   i_pl_data                      payload word
//   o_flit, o_transmit             flit and request to the Router local input
//   i_send                         Router on/off grant
//   o_busy                         packet in flight
//   o_drop                         one-cycle pulse on a discarded descriptor
//
// Optional feature macro: PACKET_INJECTOR_STATS_EN adds saturating 32-bit
// counters o_stat_pkts, o_stat_stall and o_stat_drops.

package router_pkg;
  localparam int unsigned X_W        = 2;
  localparam int unsigned Y_W        = 2;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned HEAD_LEN_W = DATA_W - 2 * X_W - 2 * Y_W;

  typedef struct packed {
    logic [X_W-1:0] xaddr;
    logic [Y_W-1:0] yaddr;
  } router_conf_t;

  typedef enum logic [1:0] {
    FT_NONE = 2'd0,
    FT_HEAD = 2'd1,
    FT_BODY = 2'd2,
    FT_TAIL = 2'd3
  } flit_type_t;

  // HEAD flit payload layout
  typedef struct packed {
    logic [X_W-1:0]        dst_x;
    logic [Y_W-1:0]        dst_y;
    logic [X_W-1:0]        src_x;
    logic [Y_W-1:0]        src_y;
    logic [HEAD_LEN_W-1:0] len;
  } head_t;

  typedef struct packed {
    flit_type_t        ftype;
    logic [DATA_W-1:0] data;
  } FLIT_t;
endpackage

module packet_injector
  import router_pkg::*;
#(
  parameter router_conf_t router_conf = '{xaddr: '0, yaddr: '0},
  parameter int unsigned  MAX_LEN     = 8,
  parameter int unsigned  LEN_W       = 4,
  parameter int unsigned  PL_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_desc_valid,
  output logic              o_desc_ready,
  input  logic [X_W-1:0]    i_desc_dst_x,
  input  logic [Y_W-1:0]    i_desc_dst_y,
  input  logic [LEN_W-1:0]  i_desc_len,
  input  logic              i_pl_valid,
  output logic              o_pl_ready,
  input  logic [DATA_W-1:0] i_pl_data,
  output FLIT_t             o_flit,
  output logic              o_transmit,
  input  logic              i_send,
  output logic              o_busy,
  output logic              o_drop
`ifdef PACKET_INJECTOR_STATS_EN
  ,
  output logic [31:0]       o_stat_pkts,
  output logic [31:0]       o_stat_stall,
  output logic [31:0]       o_stat_drops
`endif
);

  localparam int unsigned PTR_W = $clog2(PL_DEPTH);
  localparam int unsigned CNT_W = $clog2(PL_DEPTH + 1);

  // Elaboration-time parameter sanity
  if (LEN_W > HEAD_LEN_W) begin : g_len_w_chk
    $error("packet_injector: LEN_W does not fit the HEAD len field");
  end
  if (MAX_LEN == 0 || MAX_LEN >= (32'd1 << LEN_W)) begin : g_max_len_chk
    $error("packet_injector: MAX_LEN must be 1..2**LEN_W-1");
  end
  if (PL_DEPTH < 2 || (PL_DEPTH & (PL_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("packet_injector: PL_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEAD    = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  FLIT_t             flit_d;
  logic              transmit_d, desc_ready_d, pl_ready_d, busy_d, drop_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;

  logic [DATA_W-1:0] mem [PL_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop, xfer, desc_fire, len_ok, load_payload;
  head_t             head;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, next flit and FIFO pop decision
  always_comb begin
    state_d      = state_q;
    flit_d       = o_flit;
    transmit_d   = o_transmit;
    remaining_d  = remaining_q;
    drop_d       = 1'b0;
    pop          = 1'b0;
    load_payload = 1'b0;
    push         = i_pl_valid && o_pl_ready;
    xfer         = o_transmit && i_send;
    desc_fire    = i_desc_valid && o_desc_ready;
    len_ok       = (i_desc_len != '0) && (32'(i_desc_len) <= MAX_LEN);
    head         = '{dst_x: i_desc_dst_x,
                     dst_y: i_desc_dst_y,
                     src_x: router_conf.xaddr,
                     src_y: router_conf.yaddr,
                     len:   HEAD_LEN_W'(i_desc_len)};

    case (state_q)
      S_IDLE: begin
        if (desc_fire) begin
          if (len_ok) begin
            flit_d.ftype = FT_HEAD;
            flit_d.data  = head;
            transmit_d   = 1'b1;
            remaining_d  = i_desc_len;
            state_d      = S_HEAD;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_HEAD: begin
        if (xfer) begin
          load_payload = 1'b1;
          state_d      = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        // remaining==0 means the TAIL is already sitting in the output register
        if (remaining_q == '0) begin
          if (xfer) begin
            transmit_d = 1'b0;
            state_d    = S_IDLE;
          end
        end else if (!o_transmit || xfer) begin
          load_payload = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Refill the output register from the FIFO, or bubble when it is empty
    if (load_payload) begin
      if (count_q != '0) begin
        pop          = 1'b1;
        flit_d.ftype = (remaining_q == LEN_W'(1)) ? FT_TAIL : FT_BODY;
        flit_d.data  = mem[rd_ptr_q];
        remaining_d  = remaining_q - LEN_W'(1);
        transmit_d   = 1'b1;
      end else begin
        transmit_d = 1'b0;
      end
    end

    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    desc_ready_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    pl_ready_d   = (count_d < CNT_W'(PL_DEPTH));
  end

  // Registered outputs and packet bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_flit       <= '0;
      o_transmit   <= 1'b0;
      o_desc_ready <= 1'b0;
      o_pl_ready   <= 1'b0;
      o_busy       <= 1'b0;
      o_drop       <= 1'b0;
      remaining_q  <= '0;
    end else begin
      o_flit       <= flit_d;
      o_transmit   <= transmit_d;
      o_desc_ready <= desc_ready_d;
      o_pl_ready   <= pl_ready_d;
      o_busy       <= busy_d;
      o_drop       <= drop_d;
      remaining_q  <= remaining_d;
    end
  end

  // Payload FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Payload FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_pl_data;
  end

`ifdef PACKET_INJECTOR_STATS_EN
  logic tail_xfer;
  assign tail_xfer = (state_q == S_PAYLOAD) && (remaining_q == '0) && xfer;

  // Saturating event counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_stat_pkts  <= '0;
      o_stat_stall <= '0;
      o_stat_drops <= '0;
    end else begin
      if (tail_xfer && (o_stat_pkts != '1))
        o_stat_pkts <= o_stat_pkts + 32'd1;
      if (o_transmit && !i_send && (o_stat_stall != '1))
        o_stat_stall <= o_stat_stall + 32'd1;
      if (drop_d && (o_stat_drops != '1))
        o_stat_drops <= o_stat_drops + 32'd1;
    end
  end
`endif

endmodule
